// File: rtl/sound_pkg.sv
// Shared types and constants for the pong sound sequencer.
// Event ids are also the bit index + 1 of the pending vector {score, paddle, wall}.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] ID_NONE   = 2'd0;
    localparam logic [1:0] ID_WALL   = 2'd1;
    localparam logic [1:0] ID_PADDLE = 2'd2;
    localparam logic [1:0] ID_SCORE  = 2'd3;

    localparam int HP_W_DEFAULT = 18;
    localparam int T_W_DEFAULT  = 24;

    // Fixed priority: score > paddle > wall.
    function automatic logic [1:0] prio_id(input logic [2:0] pend);
        if (pend[2])      return ID_SCORE;
        else if (pend[1]) return ID_PADDLE;
        else if (pend[0]) return ID_WALL;
        else              return ID_NONE;
    endfunction

endpackage

// File: rtl/sound_sequencer_tone_gen.sv
// Square-wave generator: phase counts 0..HP-1, pwm toggles on wrap (period 2*HP).
// load restarts at phase 0 with pwm low and has priority over run.
module tone_gen #(
    parameter int HP_W = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [HP_W-1:0] half_period,
    input  logic            run,
    output logic            pwm
);

    logic [HP_W-1:0] hp_q;
    logic [HP_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q  <= '0;
            phase <= '0;
            pwm   <= 1'b0;
        end else if (load) begin
            hp_q  <= half_period;
            phase <= '0;
            pwm   <= 1'b0;
        end else if (run) begin
            if (phase == hp_q - HP_W'(1)) begin
                phase <= '0;
                pwm   <= ~pwm;
            end else begin
                phase <= phase + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Latches game sound events, plays the highest-priority one as a timed square-wave tone,
// then holds a silent gap; score preempts a playing wall/paddle tone, mute flushes everything.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned DUR_CYCLES = 10_000_000,
    parameter int unsigned GAP_CYCLES = 1_000_000,
    parameter int unsigned HP_WALL    = 113_636,
    parameter int unsigned HP_PADDLE  = 56_818,
    parameter int unsigned HP_SCORE   = 227_272,
    parameter int          HP_W       = HP_W_DEFAULT,
    parameter int          T_W        = T_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_wall,
    input  logic       ev_paddle,
    input  logic       ev_score,
    input  logic       mute,
    output logic       AUD_PWM,
    output logic       AUD_SD,
    output logic       busy,
    output logic [1:0] active_id
);

    localparam logic [T_W-1:0] DUR_LOAD = T_W'(DUR_CYCLES - 1);
    localparam logic [T_W-1:0] GAP_LOAD = T_W'(GAP_CYCLES - 1);

    state_t          state, state_n;
    logic [2:0]      ev_q;
    logic [2:0]      pending, pending_n;
    logic [2:0]      rise, clr;
    logic [1:0]      cur_id, cur_n, gid;
    logic [T_W-1:0]  dur_cnt, dur_n;
    logic [T_W-1:0]  gap_cnt, gap_n;
    logic            tone_load;
    logic [HP_W-1:0] hp_sel;
    logic            pwm_raw;

    assign rise = {ev_score, ev_paddle, ev_wall} & ~ev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ev_q    <= '0;
            pending <= '0;
            cur_id  <= ID_NONE;
            dur_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            ev_q    <= {ev_score, ev_paddle, ev_wall};
            pending <= pending_n;
            cur_id  <= cur_n;
            dur_cnt <= dur_n;
            gap_cnt <= gap_n;
        end
    end

    always_comb begin
        state_n   = state;
        cur_n     = cur_id;
        dur_n     = dur_cnt;
        gap_n     = gap_cnt;
        clr       = 3'b000;
        tone_load = 1'b0;
        gid       = prio_id(pending);

        case (state)
            IDLE: begin
                if (pending != 3'b000) begin
                    state_n   = PLAY;
                    cur_n     = gid;
                    dur_n     = DUR_LOAD;
                    tone_load = 1'b1;
                    clr       = (gid == ID_SCORE)  ? 3'b100 :
                                (gid == ID_PADDLE) ? 3'b010 : 3'b001;
                end
            end
            PLAY: begin
                // Score cuts in on a lesser tone; a repeat score just queues.
                if (pending[2] && cur_id != ID_SCORE) begin
                    cur_n     = ID_SCORE;
                    dur_n     = DUR_LOAD;
                    tone_load = 1'b1;
                    clr       = 3'b100;
                end else if (dur_cnt == '0) begin
                    state_n = GAP;
                    gap_n   = GAP_LOAD;
                end else begin
                    dur_n = dur_cnt - T_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_n = IDLE;
                else               gap_n   = gap_cnt - T_W'(1);
            end
            default: state_n = IDLE;
        endcase

        if (mute) begin
            state_n   = IDLE;
            tone_load = 1'b0;
        end

        // Set beats clear so a re-hit of the granted event stays queued.
        pending_n = mute ? 3'b000 : ((pending & ~clr) | rise);

        case (cur_n)
            ID_SCORE:  hp_sel = HP_W'(HP_SCORE);
            ID_PADDLE: hp_sel = HP_W'(HP_PADDLE);
            default:   hp_sel = HP_W'(HP_WALL);
        endcase
    end

    tone_gen #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rst         (rst),
        .load        (tone_load),
        .half_period (hp_sel),
        .run         (state == PLAY),
        .pwm         (pwm_raw)
    );

    assign AUD_SD    = (state == PLAY);
    assign AUD_PWM   = (state == PLAY) && pwm_raw;
    assign busy      = (state != IDLE);
    assign active_id = (state == PLAY) ? cur_id : ID_NONE;

endmodule
